// File: rtl/joy_shiftreg_responder.sv
`default_nettype none
// ============================================================================
// Module   : joy_shiftreg_responder
// Purpose  : Device end of the two-joystick serial chain. It emulates a
//            cascaded pair of 74HC165-style parallel-load shift registers.
//            joy_clk and joy_load_n are sampled with the system clock, and the
//            16 joystick bits are returned serially on joy_data, MSB
//            (joy1 up) first.
// Ports    : clk         system clock (28 MHz nominal)
//            rst         asynchronous reset, active-high
//            joy_clk     shift clock from the decoder (async to clk)
//            joy_load_n  parallel load from the decoder, active-low (async)
//            joy_data    serial data back to the decoder
//            joy1_n      joystick 1 raw lines, active-low
//            joy2_n      joystick 2 raw lines, active-low
//            frame_done  one-clk pulse when the 16th shift since load lands
//            shift_count shifts since the last load, saturating at 16
// Options  : JOY_CLK_FILTER_EN - when defined, the synchronized joy_clk
//            passes through a FILT_CYCLES-sample stability filter before
//            edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module joy_shiftreg_responder #(
  parameter logic        SERIAL_FILL = 1'b1,
  parameter int unsigned FILT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  output logic       joy_data,
  input  logic [7:0] joy1_n,
  input  logic [7:0] joy2_n,
  output logic       frame_done,
  output logic [4:0] shift_count
);

  localparam logic [4:0] C_FRAME_LEN = 5'd16;

  // The filter counter cannot count towards zero samples.
  generate
    if (FILT_CYCLES == 0) begin : g_filt_cycles_invalid
      $error("FILT_CYCLES must be at least 1");
    end
  endgenerate

  logic        r_clk_meta;
  logic        r_clk_s;
  logic        r_load_meta;
  logic        r_load_s;
  logic        r_clk_d;
  logic [15:0] r_pword;
  logic [15:0] r_shreg;
  logic [4:0]  r_count;
  logic        r_frame_done;
  logic        w_clk_src;
  logic        w_clk_rise;

  // Two-FF synchronizers. They idle high so reset never produces a load
  // or a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_s     <= 1'b1;
      r_load_meta <= 1'b1;
      r_load_s    <= 1'b1;
    end else begin
      r_clk_meta  <= joy_clk;
      r_clk_s     <= r_clk_meta;
      r_load_meta <= joy_load_n;
      r_load_s    <= r_load_meta;
    end
  end

`ifdef JOY_CLK_FILTER_EN
  localparam int unsigned C_FCW = $clog2(FILT_CYCLES + 1);

  logic             r_clk_f;
  logic [C_FCW-1:0] r_filt_cnt;

  // The filtered level follows clk_s only after FILT_CYCLES consecutive
  // samples that disagree with it. Any sample that agrees restarts the
  // count, so shorter pulses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_f    <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s == r_clk_f) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == C_FCW'(FILT_CYCLES - 1)) begin
      r_clk_f    <= r_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_clk_src = r_clk_f;
`else
  assign w_clk_src = r_clk_s;
`endif

  // clk_d resets high, so a high level right after reset is not an edge.
  assign w_clk_rise = w_clk_src & ~r_clk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_d      <= 1'b1;
      r_pword      <= 16'hFFFF;
      r_shreg      <= 16'hFFFF;
      r_count      <= 5'd0;
      r_frame_done <= 1'b0;
    end else begin
      // The edge detector tracks the clock even during load. Clock activity
      // during load therefore leaves no pending edge when load is released.
      r_clk_d      <= w_clk_src;
      r_pword      <= {joy1_n, joy2_n};
      r_frame_done <= 1'b0;
      if (!r_load_s) begin
        // Transparent load. It also wins over a coincident shift edge.
        r_shreg <= r_pword;
        r_count <= 5'd0;
      end else if (w_clk_rise) begin
        r_shreg <= {r_shreg[14:0], SERIAL_FILL};
        if (r_count != C_FRAME_LEN) begin
          r_count <= r_count + 5'd1;
          if (r_count == C_FRAME_LEN - 5'd1) begin
            r_frame_done <= 1'b1;
          end
        end
      end
    end
  end

  assign joy_data    = r_shreg[15];
  assign frame_done  = r_frame_done;
  assign shift_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_joy_shiftreg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_joy_shiftreg_responder
// Purpose  : Self-checking bench for joy_shiftreg_responder. The stimulus
//            tasks update a behavioural model of the frame (latched word plus
//            bit index). Each expected output change is queued with the cycle
//            in which it must appear. A monitor pops the queue whenever the
//            DUT outputs change or frame_done is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joy_shiftreg_responder;

  localparam logic FILL = 1'b1;
  localparam int   FILT = 3;
`ifdef JOY_CLK_FILTER_EN
  localparam int   LAT   = 3 + FILT;
  localparam int   MINPH = FILT + 2;
`else
  localparam int   LAT   = 3;
  localparam int   MINPH = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       joy_clk = 1'b0;
  logic       joy_load_n = 1'b1;
  logic [7:0] joy1_n = 8'hFF;
  logic [7:0] joy2_n = 8'hFF;
  logic       joy_data;
  logic       frame_done;
  logic [4:0] shift_count;

  joy_shiftreg_responder #(.SERIAL_FILL(FILL), .FILT_CYCLES(FILT)) dut (
    .clk(clk), .rst(rst), .joy_clk(joy_clk), .joy_load_n(joy_load_n),
    .joy_data(joy_data), .joy1_n(joy1_n), .joy2_n(joy2_n),
    .frame_done(frame_done), .shift_count(shift_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned t;
    int          cnt;
    bit          d;
    bit          fd;
  } ev_t;
  ev_t q[$];

  // Frame model: the word captured at load plus the number of bits consumed.
  logic [15:0] m_word = 16'hFFFF;
  int          m_k = 0;

  function automatic bit m_bit();
    if (m_k < 16) return m_word[15 - m_k];
    return FILL;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_change(int unsigned t, int old_k, bit old_d, bit fd);
    bit nd;
    nd = m_bit();
    if (m_k != old_k || nd != old_d || fd) q.push_back('{t, m_k, nd, fd});
  endtask

  task automatic do_load(int len);
    int old_k;
    bit old_d;
    old_k = m_k;
    old_d = m_bit();
    joy_load_n = 1'b0;
    m_word = {joy1_n, joy2_n};
    m_k = 0;
    expect_change(cyc + 3, old_k, old_d, 1'b0);
    tick(len);
    joy_load_n = 1'b1;
  endtask

  task automatic do_shift(int hi, int lo);
    int old_k;
    bit old_d;
    old_k = m_k;
    old_d = m_bit();
    joy_clk = 1'b1;
    if (m_k < 16) m_k++;
    expect_change(cyc + LAT, old_k, old_d, old_k == 15);
    tick(hi);
    joy_clk = 1'b0;
    tick(lo);
  endtask

  function automatic int rph();
    return MINPH + int'($urandom_range(0, 3));
  endfunction

  // Monitor: every visible output change must match the next queued event.
  initial begin : monitor
    bit   pd;
    logic [4:0] pc;
    ev_t  e;
    pd = 1'b1;
    pc = 5'd0;
    forever begin
      @(negedge clk);
      if (!rst && (joy_data !== pd || shift_count !== pc || frame_done !== 1'b0)) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: cyc %0d cnt %0d data %0b fd %0b, expected no change",
                   cyc, shift_count, joy_data, frame_done);
        end else begin
          e = q.pop_front();
          if (cyc != e.t || int'(shift_count) != e.cnt || joy_data !== e.d || frame_done !== e.fd) begin
            fails++;
            $display("FAIL event: got cyc %0d cnt %0d data %0b fd %0b, expected cyc %0d cnt %0d data %0b fd %0b",
                     cyc, shift_count, joy_data, frame_done, e.t, e.cnt, e.d, e.fd);
          end
        end
      end
      pd = joy_data;
      pc = shift_count;
    end
  end

  initial begin
    int ph;
    // Reset state.
    tick(3);
    rst = 1'b0;
    tick(4);
    check("reset_data", 16'(joy_data), 16'h1);
    check("reset_count", 16'(shift_count), 16'h0);
    check("reset_frame_done", 16'(frame_done), 16'h0);

    // Up on joy1 and start on joy2 pressed: the 16 bits read 0, 14 ones, 0.
    joy1_n = 8'h7F;
    joy2_n = 8'hFE;
    tick(2);
    do_load(4);
    tick(2);
    ph = (MINPH > 4) ? MINPH : 4;
    for (int i = 0; i < 16; i++) do_shift(ph, ph);
    check("frame_count16", 16'(shift_count), 16'd16);

    // Shifts past the end of the frame show the fill level and saturate.
    for (int i = 0; i < 4; i++) do_shift(rph(), rph());
    check("sat_data", 16'(joy_data), 16'(FILL));
    check("sat_count", 16'(shift_count), 16'd16);

    // A load and a clock rise in the same cycle: the load wins.
    joy1_n = 8'h00;
    joy2_n = 8'hFF;
    tick(2);
    joy_clk = 1'b1;
    do_load(4);
    tick(4);
    check("coincident_data", 16'(joy_data), 16'h0);
    check("coincident_count", 16'(shift_count), 16'h0);
    joy_clk = 1'b0;
    tick(MINPH);
    for (int i = 0; i < 16; i++) do_shift(rph(), rph());

    // Reset in mid-frame, then a clean frame.
    joy1_n = 8'($urandom);
    joy2_n = 8'($urandom);
    tick(2);
    do_load(3);
    tick(2);
    for (int i = 0; i < 7; i++) do_shift(rph(), rph());
    tick(2);
    rst = 1'b1;
    #1;
    check("midrst_data", 16'(joy_data), 16'h1);
    check("midrst_count", 16'(shift_count), 16'h0);
    check("midrst_frame_done", 16'(frame_done), 16'h0);
    m_word = 16'hFFFF;
    m_k = 0;
    tick(2);
    rst = 1'b0;
    tick(4);
    joy1_n = 8'($urandom);
    joy2_n = 8'($urandom);
    tick(2);
    do_load(2);
    tick(1);
    for (int i = 0; i < 16; i++) do_shift(rph(), rph());

    // Random frames, including partial frames and saturating frames.
    for (int f = 0; f < 6; f++) begin
      joy1_n = 8'($urandom);
      joy2_n = 8'($urandom);
      tick(2);
      do_load(int'($urandom_range(2, 5)));
      tick(1 + int'($urandom_range(0, 3)));
      for (int i = 0, n = int'($urandom_range(10, 20)); i < n; i++) do_shift(rph(), rph());
      check("rand_count", 16'(shift_count), 16'(m_k));
      check("rand_data", 16'(joy_data), 16'(m_bit()));
    end

`ifdef JOY_CLK_FILTER_EN
    // A 2-clk glitch is rejected; a 4-clk high phase produces one shift.
    joy1_n = 8'h5A;
    joy2_n = 8'hC3;
    tick(2);
    do_load(3);
    tick(2);
    joy_clk = 1'b1;
    tick(2);
    joy_clk = 1'b0;
    tick(10);
    check("glitch_count", 16'(shift_count), 16'h0);
    do_shift(4, 6);
    check("filt_count", 16'(shift_count), 16'h1);
`endif

    tick(12);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
